// File: rtl/sortmax_arb_if.sv
// sortmax_arb_if: request/burst/result bus between two requesters and the sortmax arbiter
interface sortmax_arb_if #(parameter int W = 8, parameter int LW = 4);
  logic [1:0]    req;
  logic [LW-1:0] len0;
  logic [LW-1:0] len1;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic [1:0]    gnt;
  logic          busy;
  logic [W-1:0]  res;
  logic          res_valid;
  logic          res_id;
  logic          err;
  modport slave (
    input  req, len0, len1, din, din_valid,
    output din_ready, gnt, busy, res, res_valid, res_id, err
  );
  modport master (
    output req, len0, len1, din, din_valid,
    input  din_ready, gnt, busy, res, res_valid, res_id, err
  );
endinterface

// File: rtl/sortmax_arb_ctrl.sv
// sortmax_arb_ctrl: round-robin scheduler sharing one running-max datapath between two requesters
module sortmax_arb_ctrl #(
  parameter int W       = 8,
  parameter int LW      = 4,
  parameter int TIMEOUT = 31
) (
  input logic           clk,
  input logic           rst,
  sortmax_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t        state, state_n;
  logic [LW-1:0] len_q, len_n, cnt, cnt_n;
  logic [5:0]    wdt, wdt_n;
  logic [W-1:0]  max_reg, max_n, res_n;
  logic          id, id_n, last_id, last_id_n, pick, grant;
  logic [1:0]    gnt_n;
  logic          busy_n, rdy_n, rv_n, rid_n, err_n;
  logic          beat, zero_len, last_beat, tmo;
  assign beat      = bus.din_valid & bus.din_ready;
  assign zero_len  = len_q == '0;
  assign last_beat = beat && cnt == len_q - 1'b1;
  assign tmo       = !beat && wdt == 6'(TIMEOUT - 1);
  // on a tie the requester that was not served last wins
  assign pick      = bus.req == 2'b11 ? ~last_id : bus.req[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      cnt           <= '0;
      wdt           <= '0;
      max_reg       <= '0;
      id            <= 1'b0;
      last_id       <= 1'b1;
      bus.gnt       <= 2'b00;
      bus.busy      <= 1'b0;
      bus.din_ready <= 1'b0;
      bus.res       <= '0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_n;
      len_q         <= len_n;
      cnt           <= cnt_n;
      wdt           <= wdt_n;
      max_reg       <= max_n;
      id            <= id_n;
      last_id       <= last_id_n;
      bus.gnt       <= gnt_n;
      bus.busy      <= busy_n;
      bus.din_ready <= rdy_n;
      bus.res       <= res_n;
      bus.res_valid <= rv_n;
      bus.res_id    <= rid_n;
      bus.err       <= err_n;
    end
  end
  always_comb begin
    state_n = state == IDLE  ? (bus.req != 2'b00 ? ACCUM : IDLE) :
              state == ACCUM ? (zero_len || last_beat || tmo ? DONE : ACCUM) : IDLE;
  end
  // outputs are registered, so they are decoded from the state being entered
  always_comb begin
    grant     = state == IDLE && bus.req != 2'b00;
    id_n      = grant ? pick : id;
    len_n     = grant ? (pick ? bus.len1 : bus.len0) : len_q;
    cnt_n     = grant ? '0 : beat ? cnt + 1'b1 : cnt;
    wdt_n     = grant || beat ? '0 : state == ACCUM ? wdt + 1'b1 : wdt;
    max_n     = grant ? '0 : beat && bus.din > max_reg ? bus.din : max_reg;
    last_id_n = state == DONE ? id : last_id;
    gnt_n     = state_n == ACCUM ? (id_n ? 2'b10 : 2'b01) : 2'b00;
    busy_n    = state_n != IDLE;
    rdy_n     = state_n == ACCUM && len_n != '0;
    rv_n      = state_n == DONE;
    res_n     = rv_n ? max_n : bus.res;
    rid_n     = rv_n ? id : bus.res_id;
    err_n     = rv_n && (zero_len || tmo);
  end
endmodule

// File: tb/tb_sortmax_arb_ctrl.sv
// tb_sortmax_arb_ctrl: table-driven directed bench for the sortmax round-robin arbiter
module tb_sortmax_arb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  sortmax_arb_if #(.W(8), .LW(4)) b();
  sortmax_arb_ctrl #(.W(8), .LW(4), .TIMEOUT(31)) dut (.clk(clk), .rst(rst), .bus(b));
  typedef struct {
    logic [1:0]   req;
    logic [3:0]   l0;
    logic [3:0]   l1;
    int           nb;
    logic [119:0] d;
    bit           tog;
    bit           hold;
    logic [7:0]   res;
    logic         id;
    logic         err;
    int           lat;
  } vec_t;
  vec_t tv[9];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, " gnt"}, 32'(b.gnt), 0);
    chk({n, " busy"}, 32'(b.busy), 0);
    chk({n, " din_ready"}, 32'(b.din_ready), 0);
    chk({n, " res"}, 32'(b.res), 0);
    chk({n, " res_valid"}, 32'(b.res_valid), 0);
    chk({n, " res_id"}, 32'(b.res_id), 0);
    chk({n, " err"}, 32'(b.err), 0);
  endtask
  task automatic run(input string n, input vec_t v);
    int i = 0;
    int c = 0;
    int lat = 0;
    bit on = 1'b1;
    bit acc;
    @(negedge clk);
    b.req = v.req; b.len0 = v.l0; b.len1 = v.l1;
    @(posedge clk); #1;
    chk({n, " gnt"}, 32'(b.gnt), v.id ? 2 : 1);
    chk({n, " busy"}, 32'(b.busy), 1);
    chk({n, " grant din_ready"}, 32'(b.din_ready), (v.id ? v.l1 : v.l0) != 0);
    while (i < v.nb && c < 200) begin
      @(negedge clk);
      if (!v.hold) b.req = 2'b00;
      b.din = v.d[i*8 +: 8];
      b.din_valid = v.tog ? on : 1'b1;
      on = !on;
      acc = b.din_valid && b.din_ready;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
    end
    chk({n, " beats"}, i, v.nb);
    while (!b.res_valid && lat < 80) begin
      @(negedge clk);
      if (!v.hold) b.req = 2'b00;
      b.din_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    @(negedge clk);
    b.din_valid = 1'b0;
    if (!v.hold) b.req = 2'b00;
    chk({n, " latency"}, lat, v.lat);
    chk({n, " res_valid"}, 32'(b.res_valid), 1);
    chk({n, " res"}, 32'(b.res), 32'(v.res));
    chk({n, " res_id"}, 32'(b.res_id), 32'(v.id));
    chk({n, " err"}, 32'(b.err), 32'(v.err));
    chk({n, " done gnt"}, 32'(b.gnt), 0);
    chk({n, " done din_ready"}, 32'(b.din_ready), 0);
    @(posedge clk); #1;
    chk({n, " pulse end"}, 32'(b.res_valid), 0);
    chk({n, " idle busy"}, 32'(b.busy), 0);
  endtask
  initial begin
    b.req = 2'b00; b.len0 = '0; b.len1 = '0; b.din = '0; b.din_valid = 1'b0;
    tv[0] = '{2'b11, 4'd1, 4'd1, 1, 120'h11, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 0};
    tv[1] = '{2'b11, 4'd1, 4'd1, 1, 120'h22, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 0};
    tv[2] = '{2'b11, 4'd1, 4'd1, 1, 120'h33, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 0};
    tv[3] = '{2'b11, 4'd1, 4'd1, 1, 120'h44, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 0};
    tv[4] = '{2'b01, 4'd3, 4'd0, 3, 120'h020905, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 0};
    tv[5] = '{2'b10, 4'd0, 4'd15, 15, 120'h0e0d0c0b0a09080706050403020100, 1'b1, 1'b0, 8'd14, 1'b1, 1'b0, 0};
    tv[6] = '{2'b01, 4'd4, 4'd0, 2, 120'h0307, 1'b0, 1'b0, 8'd7, 1'b0, 1'b1, 31};
    tv[7] = '{2'b10, 4'd0, 4'd0, 0, 120'h0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1};
    tv[8] = '{2'b01, 4'd2, 4'd0, 2, 120'h64c8, 1'b0, 1'b0, 8'd200, 1'b0, 1'b0, 0};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    for (int k = 0; k < 9; k++) run($sformatf("v%0d", k), tv[k]);
    @(negedge clk);
    b.req = 2'b01; b.len0 = 4'd5;
    @(posedge clk); #1;
    chk("rst-mid gnt", 32'(b.gnt), 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b.req = 2'b00; b.din = 8'(k + 1); b.din_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    b.din_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("rst-mid");
    @(negedge clk);
    rst = 1'b0;
    run("after-rst", '{2'b11, 4'd1, 4'd1, 1, 120'h5a, 1'b0, 1'b0, 8'h5a, 1'b0, 1'b0, 0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
